linear_tile_controller: RTL and testbench

LINEAR_TILE_CONTROLLER -- requirements
Module: linear_tile_controller

---
 rtl/linear_ctrl_pkg.sv | 26 ++
 rtl/wrap_counter.sv | 50 +++++
 rtl/linear_tile_controller.sv | 189 ++++++++++++++++++
 tb/tb_linear_tile_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// linear_ctrl_pkg
// Shared types and helpers for the linear tile controller.
//   state_e     : controller FSM state encoding
//   DRAIN_CNT_W : width of the PE drain counter (pPE_LATENCY up to 15)
//   clog2_min1  : $clog2 that never returns less than 1, so a counter or
//                 address bus with a single legal value still has one bit
// -----------------------------------------------------------------------------
package linear_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam int DRAIN_CNT_W = 4;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo-pMODULUS up-counter with synchronous clear.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, forces count to 0
//   inc_i   : advance by one this cycle
//   clr_i   : return to 0 this cycle (wins over inc_i)
//   cnt_o   : current count, 0 .. pMODULUS-1
//   wrap_o  : inc_i while the count is at pMODULUS-1 (count returns to 0)
// -----------------------------------------------------------------------------
module wrap_counter
    import linear_ctrl_pkg::*;
#(
    parameter int pMODULUS = 4,
    localparam int CW = clog2_min1(pMODULUS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_max;

    assign at_max = (cnt_q == CW'(pMODULUS - 1));
    assign wrap_o = inc_i && at_max;
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = at_max ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/linear_tile_controller.sv
// -----------------------------------------------------------------------------
// linear_tile_controller
// Sequences one fully-connected layer: for every input chunk it requests the
// chunk, waits for it, then issues one PE operation per output group, and
// finally waits for the PE pipeline to drain before signalling completion.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   start        : one-cycle layer start (accepted only in IDLE)
//   abort        : synchronous cancel, returns to IDLE without done
//   data_valid   : requested input chunk is present (looked at in WAIT_DATA)
//   pe_ready     : PE accepts an issue this cycle
//   rd_en        : one-cycle chunk read request
//   pe_en        : PE issue valid
//   pe_acc_clr   : issue belongs to the first chunk
//   pe_acc_last  : issue belongs to the last chunk
//   wt_addr      : weight address = chunk*NGRP + out_grp
//   out_grp      : current output group
//   busy         : controller is not in IDLE
//   done         : one-cycle layer-complete pulse
//   stall_cnt    : (only with LINEAR_CTRL_PERF_EN) saturating count of
//                  WAIT_DATA cycles plus COMPUTE cycles with pe_ready low
//
// Build option: define LINEAR_CTRL_PERF_EN to add the stall_cnt port.
//
// PE handshake: pe_en is the valid, pe_ready the ready. An issue transfers on
// a cycle where both are high. While pe_en is high and pe_ready is low, pe_en
// and its payload (wt_addr, out_grp, pe_acc_clr, pe_acc_last) hold steady.
// rd_en/data_valid is a request/response pair: one rd_en pulse, then the
// controller waits for data_valid.
// -----------------------------------------------------------------------------
module linear_tile_controller
    import linear_ctrl_pkg::*;
#(
    parameter int pIN_FEATURE      = 14*14*32,
    parameter int pOUT_FEATURE     = 128,
    parameter int pCHANNEL         = 32,
    parameter int pOUTPUT_PARALLEL = 4,
    parameter int pPE_LATENCY      = 3,
    localparam int NCHUNK = pIN_FEATURE / pCHANNEL,
    localparam int NGRP   = pOUT_FEATURE / pOUTPUT_PARALLEL,
    localparam int WA     = clog2_min1(NCHUNK * NGRP),
    localparam int GW     = clog2_min1(NGRP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          data_valid,
    input  logic          pe_ready,
    output logic          rd_en,
    output logic          pe_en,
    output logic          pe_acc_clr,
    output logic          pe_acc_last,
    output logic [WA-1:0] wt_addr,
    output logic [GW-1:0] out_grp,
    output logic          busy,
    output logic          done
`ifdef LINEAR_CTRL_PERF_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int CW = clog2_min1(NCHUNK);

    // Refuse to build with a geometry that does not tile exactly.
    if ((pIN_FEATURE % pCHANNEL) != 0) begin : g_chk_chunk
        $error("pIN_FEATURE must be a multiple of pCHANNEL");
    end
    if ((pOUT_FEATURE % pOUTPUT_PARALLEL) != 0) begin : g_chk_grp
        $error("pOUT_FEATURE must be a multiple of pOUTPUT_PARALLEL");
    end
    if ((pPE_LATENCY < 1) || (pPE_LATENCY > 15)) begin : g_chk_lat
        $error("pPE_LATENCY must lie in 1..15");
    end

    state_e                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
    logic [CW-1:0]          chunk_q;
    logic [GW-1:0]          grp_q;
    logic                   xfer;
    logic                   cnt_clr;
    logic                   grp_wrap;
    logic                   chunk_wrap;
    logic                   drain_end;

    // ---------------------------------------------------------------- counters
    assign xfer    = pe_en && pe_ready;
    assign cnt_clr = abort || (state_q == ST_DONE);

    wrap_counter #(.pMODULUS(NGRP)) u_grp_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (xfer),
        .clr_i  (cnt_clr),
        .cnt_o  (grp_q),
        .wrap_o (grp_wrap)
    );

    // The chunk counter advances on every group wrap; its own wrap marks the
    // final group of the final chunk, which is what sends the FSM to DRAIN.
    wrap_counter #(.pMODULUS(NCHUNK)) u_chunk_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (grp_wrap),
        .clr_i  (cnt_clr),
        .cnt_o  (chunk_q),
        .wrap_o (chunk_wrap)
    );

    assign drain_end = (drain_q == DRAIN_CNT_W'(pPE_LATENCY - 1));

    always_comb begin
        drain_d = '0;
        if ((state_q == ST_DRAIN) && !drain_end && !abort) begin
            drain_d = drain_q + DRAIN_CNT_W'(1);
        end
    end

    // --------------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start)      state_d = ST_FETCH;
            ST_FETCH:                     state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: if (data_valid) state_d = ST_COMPUTE;
            ST_COMPUTE:   if (grp_wrap)   state_d = chunk_wrap ? ST_DRAIN : ST_FETCH;
            ST_DRAIN:     if (drain_end)  state_d = ST_DONE;
            ST_DONE:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // ----------------------------------------------------------------- outputs
    assign rd_en       = (state_q == ST_FETCH);
    assign pe_en       = (state_q == ST_COMPUTE);
    assign pe_acc_clr  = pe_en && (chunk_q == '0);
    assign pe_acc_last = pe_en && (chunk_q == CW'(NCHUNK - 1));
    assign wt_addr     = WA'(chunk_q) * WA'(NGRP) + WA'(grp_q);
    assign out_grp     = grp_q;
    assign busy        = (state_q != ST_IDLE);
    // An abort landing on the DONE cycle cancels the pulse.
    assign done        = (state_q == ST_DONE) && !abort;

`ifdef LINEAR_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_cycle;
    logic        start_accept;

    assign start_accept = (state_q == ST_IDLE) && start && !abort;
    assign stall_cycle  = (state_q == ST_WAIT_DATA) ||
                          ((state_q == ST_COMPUTE) && !pe_ready);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_accept) begin
            stall_cnt_d = '0;
        end else if (stall_cycle && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_linear_tile_controller.sv
// -----------------------------------------------------------------------------
// tb_linear_tile_controller
// Drives whole layers with chosen or random data_valid delays and pe_ready
// stalls. The reference is computed from the layer rules: issue k carries
// address k, group k%NGRP, clr for the first chunk, last for the last chunk;
// the done cycle is NCHUNK*(NGRP+2)+LAT+1 plus the extra wait cycles plus the
// stall cycles the bench chose in advance.
// -----------------------------------------------------------------------------
module tb_linear_tile_controller;

    localparam int IN_F     = 8;
    localparam int CH       = 4;
    localparam int OUT_F    = 8;
    localparam int OP       = 2;
    localparam int LAT      = 3;
    localparam int NCHUNK   = IN_F / CH;
    localparam int NGRP     = OUT_F / OP;
    localparam int NISSUE   = NCHUNK * NGRP;
    localparam int WA       = 3;
    localparam int GW       = 2;
    localparam int BASE_LAT = NCHUNK * (NGRP + 2) + LAT + 1;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_ABORT  = 1;
    localparam int MODE_RESET  = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          data_valid;
    logic          pe_ready;
    logic          rd_en;
    logic          pe_en;
    logic          pe_acc_clr;
    logic          pe_acc_last;
    logic [WA-1:0] wt_addr;
    logic [GW-1:0] out_grp;
    logic          busy;
    logic          done;
`ifdef LINEAR_CTRL_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    int            n_checks;
    int            n_fail;
    logic [WA-1:0] exp_q[$];
    int            dly_a[NCHUNK];
    int            stall_a[NISSUE];

    linear_tile_controller #(
        .pIN_FEATURE      (IN_F),
        .pOUT_FEATURE     (OUT_F),
        .pCHANNEL         (CH),
        .pOUTPUT_PARALLEL (OP),
        .pPE_LATENCY      (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .data_valid  (data_valid),
        .pe_ready    (pe_ready),
        .rd_en       (rd_en),
        .pe_en       (pe_en),
        .pe_acc_clr  (pe_acc_clr),
        .pe_acc_last (pe_acc_last),
        .wt_addr     (wt_addr),
        .out_grp     (out_grp),
        .busy        (busy),
        .done        (done)
`ifdef LINEAR_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // ------------------------------------------------------------ clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- checking
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_rd_en"},   rd_en,       0);
        check({pfx, "_pe_en"},   pe_en,       0);
        check({pfx, "_acc_clr"}, pe_acc_clr,  0);
        check({pfx, "_acc_lst"}, pe_acc_last, 0);
        check({pfx, "_busy"},    busy,        0);
        check({pfx, "_done"},    done,        0);
        check({pfx, "_wt_addr"}, wt_addr,     0);
        check({pfx, "_out_grp"}, out_grp,     0);
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic set_plain();
        for (int i = 0; i < NCHUNK; i++) dly_a[i] = 1;
        for (int i = 0; i < NISSUE; i++) stall_a[i] = 0;
    endtask

    task automatic pick_random();
        for (int i = 0; i < NCHUNK; i++) dly_a[i] = int'($urandom_range(1, 5));
        for (int i = 0; i < NISSUE; i++)
            stall_a[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
    endtask

    // One layer. dly_a[c] = cycles spent in WAIT_DATA for chunk c (data_valid
    // arrives on the last of them); stall_a[k] = pe_ready-low cycles before
    // issue k transfers. Every cycle is sampled at the falling edge, then the
    // inputs for the coming rising edge are driven.
    task automatic run_layer(input int mode, input int abort_issue);
        int exp_done;
        int sum_wait;
        int sum_stall;
        int k;
        int sleft;
        int di;
        int dleft;
        int rd_cnt;
        bit finished;

        exp_q.delete();
        for (int i = 0; i < NISSUE; i++) exp_q.push_back(WA'(i));
        sum_wait  = 0;
        sum_stall = 0;
        for (int i = 0; i < NCHUNK; i++) sum_wait += dly_a[i];
        for (int i = 0; i < NISSUE; i++) sum_stall += stall_a[i];
        exp_done = BASE_LAT + (sum_wait - NCHUNK) + sum_stall;

        k        = 0;
        sleft    = stall_a[0];
        di       = 0;
        dleft    = 0;
        rd_cnt   = 0;
        finished = 1'b0;

        @(negedge clk);
        for (int c = 0; (c <= exp_done + 20) && !finished; c++) begin
            if (c == 0) check("idle_before_start", busy, 0);
            else if (c <= exp_done) check("busy_in_layer", busy, 1);

            // Outside IDLE, start is noise that must be ignored.
            if (c == 0) start = 1'b1;
            else if ((mode == MODE_NORMAL) && (c <= exp_done)) start = 1'($urandom_range(0, 1));
            else start = 1'b0;

            if (rd_en) begin
                rd_cnt++;
                dleft = (di < NCHUNK) ? dly_a[di] : 1;
                di++;
                data_valid = 1'($urandom_range(0, 1));
            end else if (dleft > 0) begin
                dleft--;
                data_valid = (dleft == 0);
            end else begin
                data_valid = 1'($urandom_range(0, 1));
            end

            if (pe_en) begin
                if ((mode == MODE_ABORT) && (k == abort_issue)) begin
                    abort    = 1'b1;
                    finished = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    check("issue_count", k + 1, NISSUE);
                    pe_ready = 1'b1;
                end else begin
                    check("wt_addr",  wt_addr,     exp_q[0]);
                    check("out_grp",  out_grp,     k % NGRP);
                    check("acc_clr",  pe_acc_clr,  (k < NGRP));
                    check("acc_last", pe_acc_last, (k >= NISSUE - NGRP));
                    if (sleft > 0) begin
                        pe_ready = 1'b0;
                        sleft--;
                    end else begin
                        pe_ready = 1'b1;
                        void'(exp_q.pop_front());
                        k++;
                        sleft = (k < NISSUE) ? stall_a[k] : 0;
                    end
                end
            end else begin
                check("acc_clr_no_issue",  pe_acc_clr,  0);
                check("acc_last_no_issue", pe_acc_last, 0);
                pe_ready = 1'($urandom_range(0, 1));
            end

            if (done) begin
                if (mode == MODE_NORMAL) begin
                    check("done_cycle",  c,            exp_done);
                    check("issues_left", exp_q.size(), 0);
                    check("rd_en_count", rd_cnt,       NCHUNK);
`ifdef LINEAR_CTRL_PERF_EN
                    check("stall_cnt",   stall_cnt,    sum_wait + sum_stall);
`endif
                end else begin
                    check("spurious_done", done, 0);
                end
                finished = 1'b1;
            end

            if ((mode == MODE_RESET) && (c == exp_done - 2) && !finished) begin
                rst = 1'b0;
                #1;
                check_idle("reset_in_drain");
                finished = 1'b1;
            end

            @(negedge clk);
        end

        check("layer_end_seen", finished, 1);
        start = 1'b0;

        if (mode == MODE_NORMAL) begin
            check("busy_after_done", busy, 0);
            check("done_one_cycle",  done, 0);
        end else begin
            abort = 1'b0;
            check_idle(mode == MODE_ABORT ? "after_abort" : "reset_held");
            rst = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                check("no_done_after_cancel", done, 0);
            end
            check("idle_after_cancel", busy, 0);
        end
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        data_valid = 1'b0;
        pe_ready   = 1'b0;

        // Inputs active while reset is held must have no effect.
        repeat (2) @(negedge clk);
        start      = 1'b1;
        data_valid = 1'b1;
        pe_ready   = 1'b1;
        @(negedge clk);
        check_idle("reset");
`ifdef LINEAR_CTRL_PERF_EN
        check("reset_stall_cnt", stall_cnt, 0);
`endif
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        // Free-running layer: done 16 cycles after start.
        set_plain();
        run_layer(MODE_NORMAL, 0);

        // pe_ready low for 5 cycles while out_grp=2 of the first chunk.
        set_plain();
        stall_a[2] = 5;
        run_layer(MODE_NORMAL, 0);

        // data_valid 4 cycles after each rd_en: done at 22.
        set_plain();
        for (int i = 0; i < NCHUNK; i++) dly_a[i] = 4;
        run_layer(MODE_NORMAL, 0);

        // abort beats start in IDLE.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start_busy",  busy,  0);
        check("abort_over_start_rd_en", rd_en, 0);

        // abort during the second COMPUTE, then a clean layer from address 0.
        pick_random();
        run_layer(MODE_ABORT, NGRP + 1);
        set_plain();
        run_layer(MODE_NORMAL, 0);

        // reset during DRAIN.
        set_plain();
        run_layer(MODE_RESET, 0);
        set_plain();
        run_layer(MODE_NORMAL, 0);

        // Randomised layers.
        for (int n = 0; n < 8; n++) begin
            pick_random();
            run_layer(MODE_NORMAL, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
